// File: rtl/encdec_pkg.sv
// Shared types for the EncDec controller: FSM states, APB register offsets,
// core mode codes and codeword width codes.
package encdec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        REG_CTRL     = 2'b00,
        REG_DATA_IN  = 2'b01,
        REG_CW_WIDTH = 2'b10,
        REG_NOISE    = 2'b11
    } reg_ofs_e;

    typedef enum logic [1:0] {
        MODE_ENC  = 2'b00,
        MODE_DEC  = 2'b01,
        MODE_FULL = 2'b10,
        MODE_BAD  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        WIDTH_8    = 2'b00,
        WIDTH_16   = 2'b01,
        WIDTH_32   = 2'b10,
        WIDTH_RSVD = 2'b11
    } width_e;

endpackage

// File: rtl/encdec_apb_regs.sv
// APB slave for the EncDec controller: register decode, storage, readback
// and error signalling. Writes are refused while the controller is busy.
module encdec_apb_regs
    import encdec_pkg::*;
#(
    parameter int AMBA_WORD  = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [1:0]            addr_ofs,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [AMBA_WORD-1:0]  pwdata,
    input  logic                  busy,
    output logic [AMBA_WORD-1:0]  prdata,
    output logic                  pslverr,
    output logic                  start_req,
    output logic [1:0]            start_mode,
    output logic [DATA_WIDTH-1:0] data_in_reg,
    output logic [1:0]            width_reg,
    output logic [DATA_WIDTH-1:0] noise_reg
);

    logic [AMBA_WORD-1:0] ctrl_q, data_in_q, width_q, noise_q;
    logic                 wr, wr_ok, ctrl_wr, bad_mode;

    assign wr       = psel & penable & pwrite;
    assign wr_ok    = wr & ~busy;
    assign ctrl_wr  = reg_ofs_e'(addr_ofs) == REG_CTRL;
    assign bad_mode = pwdata[1:0] == MODE_BAD;

    // An illegal mode is still stored so software can read back what it wrote.
    assign start_req  = wr_ok & ctrl_wr & ~bad_mode;
    assign start_mode = pwdata[1:0];
    assign pslverr    = wr & (busy | (ctrl_wr & bad_mode));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_q    <= '0;
            data_in_q <= '0;
            width_q   <= '0;
            noise_q   <= '0;
        end else if (wr_ok) begin
            case (reg_ofs_e'(addr_ofs))
                REG_CTRL:     ctrl_q    <= pwdata;
                REG_DATA_IN:  data_in_q <= pwdata;
                REG_CW_WIDTH: width_q   <= pwdata;
                REG_NOISE:    noise_q   <= pwdata;
                default:      ;
            endcase
        end
    end

    always_comb begin
        prdata = '0;
        case (reg_ofs_e'(addr_ofs))
            REG_CTRL:     prdata = ctrl_q;
            REG_DATA_IN:  prdata = data_in_q;
            REG_CW_WIDTH: prdata = width_q;
            REG_NOISE:    prdata = noise_q;
            default:      prdata = '0;
        endcase
    end

    assign data_in_reg = data_in_q[DATA_WIDTH-1:0];
    assign width_reg   = width_q[1:0];
    assign noise_reg   = noise_q[DATA_WIDTH-1:0];

endmodule

// File: rtl/encdec_ctrl.sv
// EncDec controller top: APB register slice, start/wait/done sequencing of the
// core, watchdog abort and result capture.
module encdec_ctrl
    import encdec_pkg::*;
#(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int WDOG_CYCLES     = 255
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic                       PREADY,
    output logic                       PSLVERR,
    output logic                       core_start,
    output logic [1:0]                 core_mode,
    output logic [DATA_WIDTH-1:0]      core_data,
    output logic [1:0]                 core_width,
    output logic [DATA_WIDTH-1:0]      core_noise,
    input  logic                       core_done,
    input  logic [DATA_WIDTH-1:0]      core_data_out,
    input  logic [1:0]                 core_nof,
    output logic                       operation_done,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic [1:0]                 num_of_errors,
    output logic                       timeout
);

    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    state_e                state_q, state_d;
    logic [WD_W-1:0]       wd_cnt;
    logic                  busy, start_req, wd_expire;
    logic [1:0]            start_mode, width_reg;
    logic [DATA_WIDTH-1:0] data_in_reg, noise_reg;
    logic                  unused_paddr;

    assign unused_paddr = ^{PADDR[AMBA_ADDR_WIDTH-1:4], PADDR[1:0]};

    encdec_apb_regs #(
        .AMBA_WORD  (AMBA_WORD),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_regs (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .addr_ofs    (PADDR[3:2]),
        .psel        (PSEL),
        .penable     (PENABLE),
        .pwrite      (PWRITE),
        .pwdata      (PWDATA),
        .busy        (busy),
        .prdata      (PRDATA),
        .pslverr     (PSLVERR),
        .start_req   (start_req),
        .start_mode  (start_mode),
        .data_in_reg (data_in_reg),
        .width_reg   (width_reg),
        .noise_reg   (noise_reg)
    );

    assign PREADY         = 1'b1;
    assign busy           = state_q != ST_IDLE;
    assign core_start     = state_q == ST_START;
    assign operation_done = state_q == ST_DONE;
    // Count runs 0..WDOG_CYCLES-1, so WAIT lasts at most WDOG_CYCLES cycles.
    assign wd_expire      = wd_cnt == WD_W'(WDOG_CYCLES - 1);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_req) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (core_done || wd_expire) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Snapshot taken on the IDLE->START edge so it is already valid alongside core_start.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            core_mode  <= '0;
            core_data  <= '0;
            core_width <= '0;
            core_noise <= '0;
        end else if (state_q == ST_IDLE && start_req) begin
            core_mode  <= start_mode;
            core_data  <= data_in_reg;
            core_width <= width_reg;
            core_noise <= noise_reg;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)               wd_cnt <= '0;
        else if (state_q == ST_WAIT) wd_cnt <= wd_cnt + 1'b1;
        else                        wd_cnt <= '0;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            data_out      <= '0;
            num_of_errors <= '0;
            timeout       <= 1'b0;
        end else if (state_q == ST_WAIT) begin
            if (core_done) begin
                data_out      <= core_data_out;
                num_of_errors <= core_nof;
                timeout       <= 1'b0;
            end else if (wd_expire) begin
                data_out      <= '0;
                num_of_errors <= '0;
                timeout       <= 1'b1;
            end
        end
    end

endmodule
